// File: rtl/step_pkg.sv
// -----------------------------------------------------------------------------
// step_pkg
// Shared definitions for the step pulse generator:
//   - state_t      : FSM encoding (ST_IDLE / ST_RUN / ST_DONE)
//   - DEF_*        : default widths for step count, period and pulse high time
//   - RAMP_MUL     : start/ceiling period multiplier used by the optional ramp
// Configuration macro referenced by users of this package: STEP_RAMP_EN.
// -----------------------------------------------------------------------------
package step_pkg;

    localparam int DEF_CNT_W   = 16;
    localparam int DEF_DIV_W   = 16;
    localparam int DEF_PULSE_W = 4;
    localparam int RAMP_MUL    = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/step_period_timer.sv
// -----------------------------------------------------------------------------
// step_period_timer
// Pure decode of the period counter into the three timing events of a step.
// Ports:
//   i_cnt       : current period counter value
//   i_period    : current step period (CP cycles), always > PULSE_W
//   o_step_hi   : counter is inside the high phase (step will be high next)
//   o_fall_tick : last cycle of the high phase (step falls after next edge)
//   o_wrap_tick : last cycle of the period (counter wraps to 0 on next edge)
// -----------------------------------------------------------------------------
module step_period_timer
    import step_pkg::*;
#(
    parameter int DIV_W   = DEF_DIV_W,
    parameter int PULSE_W = DEF_PULSE_W
) (
    input  logic [DIV_W-1:0] i_cnt,
    input  logic [DIV_W-1:0] i_period,
    output logic             o_step_hi,
    output logic             o_fall_tick,
    output logic             o_wrap_tick
);

    assign o_step_hi   = (i_cnt < DIV_W'(PULSE_W));
    assign o_fall_tick = (i_cnt == DIV_W'(PULSE_W - 1));
    assign o_wrap_tick = (i_cnt == (i_period - DIV_W'(1)));

endmodule

// File: rtl/step_pulse_gen.sv
// -----------------------------------------------------------------------------
// step_pulse_gen
// Turns a "move N steps in direction D at period P" command into a registered
// step clock (distributor CP) and direction level (distributor M).
// Ports:
//   CP, CR      : clock (rising edge) / async active-low reset
//   start       : command strobe, accepted only in IDLE (stop has priority)
//   stop        : abort request while running
//   dir_in      : direction of the new move (1 = forward)
//   steps_in    : number of steps to issue
//   period_in   : step period in CP cycles (clamped to at least PULSE_W+1)
//   step, M     : registered step clock and direction
//   busy, done  : move in progress / one-cycle end-of-move pulse
//   steps_left  : steps still to be issued
// Optional feature macro: STEP_RAMP_EN (linear accel/decel of the period).
//
// The period counter leads the step output by one cycle: step, busy and done
// are registered from the current counter/state, so the first step rises one
// cycle after start is sampled.
// -----------------------------------------------------------------------------
module step_pulse_gen
    import step_pkg::*;
#(
    parameter int CNT_W   = DEF_CNT_W,
    parameter int DIV_W   = DEF_DIV_W,
    parameter int PULSE_W = DEF_PULSE_W
) (
    input  logic             CP,
    input  logic             CR,
    input  logic             start,
    input  logic             stop,
    input  logic             dir_in,
    input  logic [CNT_W-1:0] steps_in,
    input  logic [DIV_W-1:0] period_in,
    output logic             step,
    output logic             M,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] steps_left
);

    localparam logic [DIV_W-1:0] MIN_PERIOD = DIV_W'(PULSE_W + 1);

    state_t           r_state;
    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] r_period;
    logic [CNT_W-1:0] r_left;
    logic             r_abort;
    logic             r_step;
    logic             r_m;
    logic             r_busy;
    logic             r_done;

    logic             w_step_hi;
    logic             w_fall;
    logic             w_wrap;
    logic             w_run;
    logic             w_accept;
    logic             w_zero_cmd;
    logic             w_abort_req;
    logic             w_kill;
    logic             w_abort_now;
    logic             w_dec;
    logic [DIV_W-1:0] w_floor;
    logic [DIV_W-1:0] w_first;

    step_period_timer #(
        .DIV_W   (DIV_W),
        .PULSE_W (PULSE_W)
    ) u_timer (
        .i_cnt       (r_cnt),
        .i_period    (r_period),
        .o_step_hi   (w_step_hi),
        .o_fall_tick (w_fall),
        .o_wrap_tick (w_wrap)
    );

    // Guarantee at least one low cycle per period.
    assign w_floor = (period_in < MIN_PERIOD) ? MIN_PERIOD : period_in;

`ifdef STEP_RAMP_EN
    localparam logic [DIV_W+1:0] MAX_PERIOD = {2'b00, {DIV_W{1'b1}}};

    logic [DIV_W+1:0] w_x4;
    logic [DIV_W-1:0] w_ceil;
    logic [DIV_W-1:0] r_floor;
    logic [DIV_W-1:0] r_ceil;
    logic [CNT_W-1:0] r_accel;

    assign w_x4 = {2'b00, period_in} * (DIV_W+2)'(RAMP_MUL);

    // Ramp ceiling saturates at the counter range and never undercuts the floor.
    always_comb begin
        w_ceil = (w_x4 > MAX_PERIOD) ? {DIV_W{1'b1}} : w_x4[DIV_W-1:0];
        if (w_ceil < w_floor) w_ceil = w_floor;
    end

    assign w_first = w_ceil;
`else
    assign w_first = w_floor;
`endif

    assign w_run      = (r_state == ST_RUN);
    assign w_accept   = (r_state == ST_IDLE) && start && !stop && (steps_in != '0);
    assign w_zero_cmd = (r_state == ST_IDLE) && start && !stop && (steps_in == '0);

    // An abort arriving while step is low ends the move at once and must also
    // suppress a pulse that the counter is about to start. If step is high the
    // pulse is finished and counted; the move ends on its fall tick.
    assign w_abort_req = w_run && (stop || r_abort);
    assign w_kill      = w_abort_req && !r_step;
    assign w_abort_now = w_abort_req && !(r_step && w_step_hi && !w_fall);
    assign w_dec       = w_run && w_fall && !w_kill && (r_left != '0);

    always_ff @(posedge CP or negedge CR) begin
        if (!CR) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_period <= '0;
            r_left   <= '0;
            r_abort  <= 1'b0;
            r_step   <= 1'b0;
            r_m      <= 1'b1;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
`ifdef STEP_RAMP_EN
            r_floor  <= '0;
            r_ceil   <= '0;
            r_accel  <= '0;
`endif
        end else begin
            r_busy <= w_run;
            r_done <= (r_state == ST_DONE) || w_zero_cmd;
            r_step <= w_run && w_step_hi && !w_kill;

            if (w_dec) r_left <= r_left - CNT_W'(1);

            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_m      <= dir_in;
                        r_left   <= steps_in;
                        r_period <= w_first;
                        r_cnt    <= '0;
                        r_abort  <= 1'b0;
`ifdef STEP_RAMP_EN
                        r_floor  <= w_floor;
                        r_ceil   <= w_ceil;
                        r_accel  <= '0;
`endif
                        r_state  <= ST_RUN;
                    end
                end

                ST_RUN: begin
                    r_cnt <= w_wrap ? '0 : r_cnt + DIV_W'(1);
`ifdef STEP_RAMP_EN
                    // Period update at the end of each step: decelerate once the
                    // remaining steps fit in the distance spent accelerating.
                    if (w_wrap) begin
                        if (r_left <= r_accel) begin
                            if (r_period < r_ceil) r_period <= r_period + DIV_W'(1);
                        end else if (r_period > r_floor) begin
                            r_period <= r_period - DIV_W'(1);
                            r_accel  <= r_accel + CNT_W'(1);
                        end
                    end
`endif
                    if (w_abort_now) begin
                        r_abort <= 1'b0;
                        r_state <= ST_DONE;
                    end else if (w_abort_req) begin
                        r_abort <= 1'b1;
                    end else if (w_wrap && (r_left == '0)) begin
                        r_state <= ST_DONE;
                    end
                end

                ST_DONE: begin
                    r_cnt   <= '0;
                    r_state <= ST_IDLE;
                end

                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign step       = r_step;
    assign M          = r_m;
    assign busy       = r_busy;
    assign done       = r_done;
    assign steps_left = r_left;

endmodule

// File: tb/tb_step_pulse_gen.sv
// -----------------------------------------------------------------------------
// tb_step_pulse_gen
// Self-checking bench for step_pulse_gen. The reference model describes a move
// as a list of pulse start cycles (cycle k = interval after the k-th rising
// edge, start sampled at edge 0) and derives step/busy/done/steps_left/M per
// cycle from that list. Honours STEP_RAMP_EN for the period sequence.
// -----------------------------------------------------------------------------
module tb_step_pulse_gen;

    localparam int CNT_W = 16;
    localparam int DIV_W = 16;
    localparam int PW    = 4;

    logic             CP = 1'b0;
    logic             CR = 1'b0;
    logic             start = 1'b0;
    logic             stop = 1'b0;
    logic             dir_in = 1'b0;
    logic [CNT_W-1:0] steps_in = '0;
    logic [DIV_W-1:0] period_in = '0;
    logic             step;
    logic             M;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] steps_left;

    int n_cmp = 0;
    int n_bad = 0;

    int per[64];
    int st[65];
    int model_left = 0;
    bit model_m = 1'b1;

    step_pulse_gen #(
        .CNT_W   (CNT_W),
        .DIV_W   (DIV_W),
        .PULSE_W (PW)
    ) dut (
        .CP         (CP),
        .CR         (CR),
        .start      (start),
        .stop       (stop),
        .dir_in     (dir_in),
        .steps_in   (steps_in),
        .period_in  (period_in),
        .step       (step),
        .M          (M),
        .busy       (busy),
        .done       (done),
        .steps_left (steps_left)
    );

    always #5 CP = ~CP;

    // Period of every step, then the cycle in which each pulse first goes high.
    task automatic build_periods(input int n, input int pin);
        int flo, cei, p, acc, left;
        flo = (pin < PW + 1) ? PW + 1 : pin;
        cei = (4 * pin > 65535) ? 65535 : 4 * pin;
        if (cei < flo) cei = flo;
`ifdef STEP_RAMP_EN
        p = cei;
`else
        p = flo;
`endif
        acc = 0;
        for (int i = 0; i < n; i++) begin
            per[i] = p;
`ifdef STEP_RAMP_EN
            left = n - (i + 1);
            if (left <= acc) begin
                if (p < cei) p = p + 1;
            end else if (p > flo) begin
                p = p - 1;
                acc = acc + 1;
            end
`else
            left = 0;
            acc = left;
`endif
        end
        st[0] = 1;
        for (int j = 0; j < n; j++) st[j+1] = st[j] + per[j];
    endtask

    // s == 0: no abort; otherwise stop is sampled at edge s (1 <= s < st[n]).
    task automatic run_move(input string name, input int n, input int pin,
                            input bit d, input int s);
        int e, done_c, last_hi, rises, e_left;
        bit hi, bad, prev, e_step, e_busy, e_done;
        build_periods(n, pin);
        e = n;
        done_c = st[n];
        if (s != 0) begin
            e = 0; hi = 0; last_hi = 0;
            for (int j = 0; j < n; j++) begin
                if (st[j] <= s - 1) e++;
                if (st[j] <= s - 1 && s - 1 <= st[j] + PW - 1) begin
                    hi = 1;
                    last_hi = st[j] + PW - 1;
                end
            end
            done_c = s + 1;
            if (hi && last_hi + 1 > done_c) done_c = last_hi + 1;
        end

        @(negedge CP);
        start = 1; stop = 0; dir_in = d;
        steps_in = CNT_W'(n); period_in = DIV_W'(pin);
        @(posedge CP); #1;
        start = 0;
        steps_in = CNT_W'($urandom_range(1, 9));
        period_in = DIV_W'($urandom_range(0, 30));
        dir_in = 1'($urandom);

        bad = 0; rises = 0; prev = 0;
        for (int k = 0; k <= done_c + 2; k++) begin
            stop  = (s != 0) && (k == s - 1);
            start = (k == 3) && (done_c > 8);
            @(negedge CP);
            e_step = 0;
            e_left = n;
            for (int j = 0; j < e; j++) begin
                if (k >= st[j] && k <= st[j] + PW - 1) e_step = 1;
                if (st[j] + PW - 1 <= k) e_left--;
            end
            e_busy = (k >= 1) && (k < done_c);
            e_done = (k == done_c);
            if (step && !prev) rises++;
            prev = step;
            if (!bad) begin
                n_cmp += 5;
                if (step !== e_step) begin
                    n_bad++; bad = 1;
                    $display("FAIL %s cyc %0d step got %b want %b", name, k, step, e_step);
                end
                if (busy !== e_busy) begin
                    n_bad++; bad = 1;
                    $display("FAIL %s cyc %0d busy got %b want %b", name, k, busy, e_busy);
                end
                if (done !== e_done) begin
                    n_bad++; bad = 1;
                    $display("FAIL %s cyc %0d done got %b want %b", name, k, done, e_done);
                end
                if (steps_left !== CNT_W'(e_left)) begin
                    n_bad++; bad = 1;
                    $display("FAIL %s cyc %0d steps_left got %0d want %0d", name, k, steps_left, e_left);
                end
                if (M !== d) begin
                    n_bad++; bad = 1;
                    $display("FAIL %s cyc %0d M got %b want %b", name, k, M, d);
                end
            end
            @(posedge CP); #1;
            model_left = e_left;
        end
        stop = 0; start = 0;
        model_m = d;
        n_cmp++;
        if (rises != e) begin
            n_bad++;
            $display("FAIL %s pulse_count got %0d want %0d", name, rises, e);
        end
    endtask

    task automatic test_reset();
        CR = 0;
        #12;
        n_cmp += 5;
        if (step !== 1'b0) begin n_bad++; $display("FAIL reset step got %b want 0", step); end
        if (M !== 1'b1) begin n_bad++; $display("FAIL reset M got %b want 1", M); end
        if (busy !== 1'b0) begin n_bad++; $display("FAIL reset busy got %b want 0", busy); end
        if (done !== 1'b0) begin n_bad++; $display("FAIL reset done got %b want 0", done); end
        if (steps_left !== '0) begin n_bad++; $display("FAIL reset steps_left got %0d want 0", steps_left); end
        @(negedge CP);
        CR = 1;
        repeat (2) @(posedge CP);
        #1;
        n_cmp += 2;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL post_reset busy got %b want 0", busy); end
        if (step !== 1'b0) begin n_bad++; $display("FAIL post_reset step got %b want 0", step); end
        model_left = 0;
        model_m = 1;
    endtask

    task automatic test_basic();
        run_move("basic", 3, 10, 1'b1, 0);
    endtask

    task automatic test_clamp();
        run_move("clamp", 2, 2, 1'b0, 0);
    endtask

    task automatic test_zero_step();
        @(negedge CP);
        start = 1; stop = 0; steps_in = '0; period_in = 16'd10; dir_in = ~model_m;
        @(posedge CP); #1;
        start = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge CP);
            n_cmp += 4;
            if (done !== (k == 0)) begin n_bad++; $display("FAIL zero cyc %0d done got %b want %b", k, done, (k == 0)); end
            if (busy !== 1'b0) begin n_bad++; $display("FAIL zero cyc %0d busy got %b want 0", k, busy); end
            if (step !== 1'b0) begin n_bad++; $display("FAIL zero cyc %0d step got %b want 0", k, step); end
            if (M !== model_m) begin n_bad++; $display("FAIL zero cyc %0d M got %b want %b", k, M, model_m); end
            @(posedge CP); #1;
        end
    endtask

    task automatic test_stop_mid_pulse();
        run_move("stop_mid", 5, 10, 1'b1, 12);
    endtask

    task automatic test_start_stop_same();
        @(negedge CP);
        start = 1; stop = 1; steps_in = 16'd5; period_in = 16'd8; dir_in = ~model_m;
        @(posedge CP); #1;
        start = 0; stop = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge CP);
            n_cmp += 4;
            if (busy !== 1'b0) begin n_bad++; $display("FAIL start_stop cyc %0d busy got %b want 0", k, busy); end
            if (done !== 1'b0) begin n_bad++; $display("FAIL start_stop cyc %0d done got %b want 0", k, done); end
            if (steps_left !== CNT_W'(model_left)) begin n_bad++; $display("FAIL start_stop cyc %0d steps_left got %0d want %0d", k, steps_left, model_left); end
            if (M !== model_m) begin n_bad++; $display("FAIL start_stop cyc %0d M got %b want %b", k, M, model_m); end
            @(posedge CP); #1;
        end
    endtask

    task automatic test_reset_mid_move();
        int n_done, n_step, n_busy;
        @(negedge CP);
        start = 1; stop = 0; steps_in = 16'd5; period_in = 16'd10; dir_in = 0;
        @(posedge CP); #1;
        start = 0;
        for (int k = 0; k < 13; k++) begin
            @(posedge CP); #1;
        end
        CR = 0;
        #1;
        n_cmp += 4;
        if (step !== 1'b0) begin n_bad++; $display("FAIL rst_mid step got %b want 0", step); end
        if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_mid busy got %b want 0", busy); end
        if (steps_left !== '0) begin n_bad++; $display("FAIL rst_mid steps_left got %0d want 0", steps_left); end
        if (M !== 1'b1) begin n_bad++; $display("FAIL rst_mid M got %b want 1", M); end
        repeat (2) @(negedge CP);
        CR = 1;
        n_done = 0; n_step = 0; n_busy = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge CP);
            if (done) n_done++;
            if (step) n_step++;
            if (busy) n_busy++;
        end
        n_cmp += 3;
        if (n_done != 0) begin n_bad++; $display("FAIL rst_mid done_pulses got %0d want 0", n_done); end
        if (n_step != 0) begin n_bad++; $display("FAIL rst_mid step_cycles got %0d want 0", n_step); end
        if (n_busy != 0) begin n_bad++; $display("FAIL rst_mid busy_cycles got %0d want 0", n_busy); end
        @(posedge CP); #1;
        model_left = 0;
        model_m = 1;
    endtask

    task automatic test_random();
        int n, pin, s;
        bit d;
        for (int i = 0; i < 10; i++) begin
            n   = $urandom_range(1, 6);
            pin = $urandom_range(0, 14);
            d   = 1'($urandom);
            build_periods(n, pin);
            s = ($urandom_range(0, 1) == 1) ? $urandom_range(1, st[n] - 1) : 0;
            run_move("random", n, pin, d, s);
        end
    endtask

`ifdef STEP_RAMP_EN
    task automatic test_ramp();
        run_move("ramp", 20, 10, 1'b1, 0);
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_clamp();
        test_zero_step();
        test_stop_mid_pulse();
        test_start_stop_same();
        test_reset_mid_move();
        test_random();
`ifdef STEP_RAMP_EN
        test_ramp();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
